// File: rtl/bus_master_port_if.sv
// Signal bundle between one master's transfer engine, the arbiter lines and
// the bus_master_port endpoint that sits between them.
interface bus_master_port_if;
  // Request/grant: m_req stays high until the arbiter answers with m_grant.
  // The master holds bus_util high for as long as it owns the bus.
  // A grant that drops while the master still owns the bus means one of two things:
  // split (split_ind high) or preemption.
  logic       txn_start;
  logic       txn_end;
  logic       split_ind;
  logic       m_grant;
  logic       m_req;
  logic       bus_util;
  logic       owner;
  logic       busy;
  logic       resumed;
  logic       preempted;
  logic       timeout;
  logic [2:0] state;

  modport master (
    input  txn_start, txn_end, split_ind, m_grant,
    output m_req, bus_util, owner, busy, resumed, preempted, timeout, state
  );

  modport slave (
    output txn_start, txn_end, split_ind, m_grant,
    input  m_req, bus_util, owner, busy, resumed, preempted, timeout, state
  );
endinterface

// File: rtl/bus_master_port.sv
// Master-side arbitration endpoint: requests the bus, owns it on grant,
// and tells a split (wait for re-grant) apart from a preemption (re-request).
module bus_master_port #(
  parameter int CNT_W         = 12,
  parameter int REQ_TIMEOUT   = 256,
  parameter int SPLIT_TIMEOUT = 4095
) (
  input  logic               clk,
  input  logic               rst,
  bus_master_port_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_REQ        = 3'd1,
    S_OWN        = 3'd2,
    S_RELEASE    = 3'd3,
    S_SPLIT_WAIT = 3'd4,
    S_PREEMPT    = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] REQ_LAST   = CNT_W'(REQ_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SPLIT_LAST = CNT_W'(SPLIT_TIMEOUT - 1);
  localparam logic             REQ_TO_EN   = (REQ_TIMEOUT != 0);
  localparam logic             SPLIT_TO_EN = (SPLIT_TIMEOUT != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             first_own_q, first_own_d;
  logic             resumed_d, preempted_d, timeout_d;

  logic m_req_q, bus_util_q, owner_q, busy_q;
  logic resumed_q, preempted_q, timeout_q;

  // Saturating so a disabled timeout can never wrap into a false match.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    resumed_d   = 1'b0;
    preempted_d = 1'b0;
    timeout_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.txn_start) begin
          state_d = S_REQ;
          cnt_d   = '0;
        end
      end

      S_REQ: begin
        if (bus.m_grant) begin
          state_d = S_OWN;
        end else if (REQ_TO_EN && (cnt_q == REQ_LAST)) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_OWN: begin
        // The grant line is ignored for one cycle after taking ownership.
        // This lets the arbiter see bus_util before any drop is acted on.
        if (bus.txn_end) begin
          state_d = S_RELEASE;
        end else if (!first_own_q && !bus.m_grant) begin
          if (bus.split_ind) begin
            state_d = S_SPLIT_WAIT;
            cnt_d   = '0;
          end else begin
            state_d     = S_PREEMPT;
            preempted_d = 1'b1;
          end
        end
      end

      S_RELEASE: begin
        state_d = S_IDLE;
      end

      S_SPLIT_WAIT: begin
        if (bus.m_grant) begin
          state_d   = S_OWN;
          resumed_d = 1'b1;
        end else if (SPLIT_TO_EN && (cnt_q == SPLIT_LAST)) begin
          state_d   = S_IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_PREEMPT: begin
        state_d = S_REQ;
        cnt_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    first_own_d = (state_d == S_OWN) && (state_q != S_OWN);
  end

  // Outputs are registered from the next state, so they line up with the state register.
  // busy is the exception: it is taken from the current state and trails by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      first_own_q <= 1'b0;
      m_req_q     <= 1'b0;
      bus_util_q  <= 1'b0;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      resumed_q   <= 1'b0;
      preempted_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      first_own_q <= first_own_d;
      m_req_q     <= (state_d == S_REQ);
      bus_util_q  <= (state_d == S_OWN);
      owner_q     <= (state_d == S_OWN);
      busy_q      <= (state_q != S_IDLE);
      resumed_q   <= resumed_d;
      preempted_q <= preempted_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.m_req     = m_req_q;
  assign bus.bus_util  = bus_util_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = busy_q;
  assign bus.resumed   = resumed_q;
  assign bus.preempted = preempted_q;
  assign bus.timeout   = timeout_q;
  assign bus.state     = state_q;

  a_owner_is_util: assert property (@(posedge clk) disable iff (rst)
    owner_q == bus_util_q);
  a_pulses_exclusive: assert property (@(posedge clk) disable iff (rst)
    $onehot0({resumed_q, preempted_q, timeout_q}));
  a_req_not_util: assert property (@(posedge clk) disable iff (rst)
    !(m_req_q && bus_util_q));

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: two instances (finite and disabled timeouts) on shared stimulus,
// each checked every cycle against a phase/cycle-count reference model.
module tb_bus_master_port;

  localparam int A_REQ_TO   = 8;
  localparam int A_SPLIT_TO = 40;

  localparam int P_IDLE  = 0;
  localparam int P_REQ   = 1;
  localparam int P_OWN   = 2;
  localparam int P_REL   = 3;
  localparam int P_SPLIT = 4;
  localparam int P_PRE   = 5;

  typedef struct {
    int         ph;
    int         n;
    logic       m_req;
    logic       bus_util;
    logic       owner;
    logic       busy;
    logic       resumed;
    logic       preempted;
    logic       timeout;
    logic [2:0] state;
  } mdl_t;

  logic clk;
  logic rst;
  logic txn_start, txn_end, split_ind, m_grant;
  logic chk_en;
  int   n_checks;
  int   n_fail;
  mdl_t ma, mb;

  bus_master_port_if ifa ();
  bus_master_port_if ifb ();

  assign ifa.txn_start = txn_start;
  assign ifa.txn_end   = txn_end;
  assign ifa.split_ind = split_ind;
  assign ifa.m_grant   = m_grant;
  assign ifb.txn_start = txn_start;
  assign ifb.txn_end   = txn_end;
  assign ifb.split_ind = split_ind;
  assign ifb.m_grant   = m_grant;

  bus_master_port #(.CNT_W(12), .REQ_TIMEOUT(A_REQ_TO), .SPLIT_TIMEOUT(A_SPLIT_TO)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.master)
  );

  bus_master_port #(.CNT_W(12), .REQ_TIMEOUT(0), .SPLIT_TIMEOUT(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase + 1-based count of cycles spent in that phase.
  function automatic mdl_t model_step(input mdl_t m, input logic r, input logic s,
                                      input logic e, input logic sp, input logic g,
                                      input int to_req, input int to_split);
    mdl_t o;
    int   nph;
    o           = m;
    o.resumed   = 1'b0;
    o.preempted = 1'b0;
    o.timeout   = 1'b0;
    if (r) begin
      o.ph = P_IDLE; o.n = 1;
      o.m_req = 1'b0; o.bus_util = 1'b0; o.owner = 1'b0; o.busy = 1'b0;
      o.state = 3'd0;
      return o;
    end
    nph = m.ph;
    if (m.ph == P_IDLE && s) nph = P_REQ;
    if (m.ph == P_REQ) begin
      if (g) nph = P_OWN;
      else if (to_req != 0 && m.n == to_req) begin nph = P_IDLE; o.timeout = 1'b1; end
    end
    if (m.ph == P_OWN) begin
      if (e) nph = P_REL;
      else if (m.n > 1 && !g) nph = sp ? P_SPLIT : P_PRE;
    end
    if (m.ph == P_REL) nph = P_IDLE;
    if (m.ph == P_SPLIT) begin
      if (g) begin nph = P_OWN; o.resumed = 1'b1; end
      else if (to_split != 0 && m.n == to_split) begin nph = P_IDLE; o.timeout = 1'b1; end
    end
    if (m.ph == P_PRE) nph = P_REQ;
    o.preempted = (nph == P_PRE);
    o.n         = (nph == m.ph) ? m.n + 1 : 1;
    o.busy      = (m.ph != P_IDLE);
    o.m_req     = (nph == P_REQ);
    o.bus_util  = (nph == P_OWN);
    o.owner     = (nph == P_OWN);
    o.state     = 3'(nph);
    o.ph        = nph;
    return o;
  endfunction

  function automatic logic [9:0] pack_m(input mdl_t m);
    return {m.m_req, m.bus_util, m.owner, m.busy, m.resumed, m.preempted, m.timeout, m.state};
  endfunction

  always @(posedge clk) begin
    ma = model_step(ma, rst, txn_start, txn_end, split_ind, m_grant, A_REQ_TO, A_SPLIT_TO);
    mb = model_step(mb, rst, txn_start, txn_end, split_ind, m_grant, 0, 0);
  end

  // scoreboard helpers
  task automatic cmpv(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp1(input string name, input logic act, input logic exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp3(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Vector order: m_req bus_util owner busy resumed preempted timeout state[2:0]
  always @(negedge clk) begin
    if (chk_en) begin
      cmpv("a_outputs", {ifa.m_req, ifa.bus_util, ifa.owner, ifa.busy, ifa.resumed,
                         ifa.preempted, ifa.timeout, ifa.state}, pack_m(ma));
      cmpv("b_outputs", {ifb.m_req, ifb.bus_util, ifb.owner, ifb.busy, ifb.resumed,
                         ifb.preempted, ifb.timeout, ifb.state}, pack_m(mb));
    end
  end

  // driver tasks: one call = one cycle; outputs visible after return belong to that cycle
  task automatic step(input logic r, input logic s, input logic e, input logic sp, input logic g);
    @(negedge clk);
    rst = r; txn_start = s; txn_end = e; split_ind = sp; m_grant = g;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // c0 start, grant in c2..c3, OWN from c3 with grant still applied
  task automatic go_own();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    cmpv({tag, "_a_zero"}, {ifa.m_req, ifa.bus_util, ifa.owner, ifa.busy, ifa.resumed,
                            ifa.preempted, ifa.timeout, ifa.state}, 10'd0);
    cmpv({tag, "_b_zero"}, {ifb.m_req, ifb.bus_util, ifb.owner, ifb.busy, ifb.resumed,
                            ifb.preempted, ifb.timeout, ifb.state}, 10'd0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; chk_en = 1'b0;
    rst = 1'b1; txn_start = 1'b0; txn_end = 1'b0; split_ind = 1'b0; m_grant = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;

    // basic transaction
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all_zero("reset");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp1("s1_req_c1", ifa.m_req, 1'b1);
    cmp1("s1_busy_c1", ifa.busy, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp1("s1_busy_c2", ifa.busy, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp1("s1_req_c3", ifa.m_req, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp1("s1_util_c4", ifa.bus_util, 1'b1);
    cmp1("s1_req_c4", ifa.m_req, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    cmp1("s1_util_c6", ifa.bus_util, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp1("s1_util_c7", ifa.bus_util, 1'b0);
    cmp3("s1_state_c7", ifa.state, 3'd3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp3("s1_state_c8", ifa.state, 3'd0);
    idle(3);

    // split, re-grant 20 cycles after the drop
    go_own();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp1("s2_util_split", ifa.bus_util, 1'b0);
    cmp1("s2_req_split", ifa.m_req, 1'b0);
    cmp3("s2_state_split", ifa.state, 3'd4);
    idle(18);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp3("s2_state_wait", ifa.state, 3'd4);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp1("s2_resumed", ifa.resumed, 1'b1);
    cmp1("s2_util_resume", ifa.bus_util, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    cmp1("s2_resumed_off", ifa.resumed, 1'b0);
    idle(3);

    // preemption and re-request
    go_own();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp1("s3_preempted", ifa.preempted, 1'b1);
    cmp1("s3_util_pre", ifa.bus_util, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cmp1("s3_req_again", ifa.m_req, 1'b1);
    cmp1("s3_preempted_off", ifa.preempted, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    cmp3("s3_state_own", ifa.state, 3'd2);
    idle(3);

    // REQ timeout (a) vs. no timeout (b)
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(8);
    cmp3("s4_state_8th_req", ifa.state, 3'd1);
    cmp1("s4_no_early_to", ifa.timeout, 1'b0);
    idle(1);
    cmp1("s4_timeout", ifa.timeout, 1'b1);
    cmp1("s4_req_dropped", ifa.m_req, 1'b0);
    cmp3("s4_state_idle", ifa.state, 3'd0);
    cmp1("s4_b_req_held", ifb.m_req, 1'b1);
    idle(1);
    cmp1("s4_timeout_off", ifa.timeout, 1'b0);
    idle(5000);
    cmp1("s4_b_req_5000", ifb.m_req, 1'b1);
    cmp1("s4_b_no_timeout", ifb.timeout, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    cmp3("s4_b_own", ifb.state, 3'd2);
    cmp3("s4_a_ignores_grant", ifa.state, 3'd0);
    idle(3);

    // grant in the timeout cycle wins
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(7);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    cmp3("s5_grant_wins", ifa.state, 3'd2);
    cmp1("s5_no_timeout", ifa.timeout, 1'b0);
    idle(3);

    // txn_end together with a grant drop
    go_own();
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp3("s5_end_wins", ifa.state, 3'd3);
    cmp1("s5_end_no_pre", ifa.preempted, 1'b0);
    idle(3);

    // grant drop masked only in the first OWN cycle
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp3("s5_first_own", ifa.state, 3'd2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp3("s5_mask_first", ifa.state, 3'd2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp3("s5_drop_seen", ifa.state, 3'd5);

    // reset in OWN and in SPLIT_WAIT
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    go_own();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_all_zero("s6_rst_own");
    go_own();
    cmp3("s6_own_again", ifa.state, 3'd2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp3("s6_in_split", ifa.state, 3'd4);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_all_zero("s6_rst_split");
    go_own();
    cmp1("s6_util_after_rst", ifa.bus_util, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    idle(3);

    // randomized traffic with varying grant density
    for (int seg = 0; seg < 15; seg++) begin
      int gp;
      gp = (seg % 3 == 0) ? 4 : ((seg % 3 == 1) ? 35 : 80);
      for (int i = 0; i < 200; i++) begin
        step(($urandom_range(0, 299) == 0),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 99) < gp));
      end
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
